// File: rtl/drone_pkg.sv
// Shared state codes and width helpers for the level control unit.
// Optional pause support is selected with UNIDADE_CONTROLE_PAUSA_EN.
package drone_pkg;

  typedef enum logic [3:0] {
    INICIAL      = 4'h0,
    VIDAS        = 4'h1,
    PREPARACAO   = 4'h2,
    ESPERA       = 4'h3,
    DESLOCAMENTO = 4'h4,
    CHECA        = 4'h5,
    PROXIMO      = 4'h6,
    PERDE_VIDA   = 4'h7,
    NOVO_NIVEL   = 4'h8,
    PAUSA        = 4'h9,
    DERROTA      = 4'hA,
    VITORIA      = 4'hB
  } estado_t;

  localparam logic [3:0] DB_INVALIDO = 4'hF;

  function automatic int largura_vidas(input int max_vidas);
    return $clog2(max_vidas + 1);
  endfunction

  function automatic int largura_nivel(input int n_niveis);
    return (n_niveis > 2) ? $clog2(n_niveis) : 1;
  endfunction

  function automatic int largura_cont(input int ciclos);
    return (ciclos > 2) ? $clog2(ciclos) : 1;
  endfunction

  function automatic logic estado_valido(
    input logic [3:0] e,
    input logic       pausa_en
  );
    return (e <= 4'hB) && (pausa_en || (e != 4'h9));
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Per-move timeout counter; fim flags the last allowed cycle.
// Clear has priority over count; the count parks at its final value.
module contador_timeout
  import drone_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int CW = largura_cont(TIMEOUT_CICLOS);
  localparam logic [CW-1:0] ULTIMO = CW'(TIMEOUT_CICLOS - 1);

  logic [CW-1:0] r_cont;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cont <= '0;
    end else if (zera) begin
      r_cont <= '0;
    end else if (conta && !fim) begin
      r_cont <= r_cont + CW'(1);
    end
  end

  assign fim = (r_cont == ULTIMO);

endmodule

// File: rtl/unidade_controle_niveis.sv
// Game level/lives controller (Moore FSM) with per-move timeout.
// Define UNIDADE_CONTROLE_PAUSA_EN to enable the PAUSA state.
module unidade_controle_niveis
  import drone_pkg::*;
#(
  parameter int MAX_VIDAS      = 3,
  parameter int N_NIVEIS       = 4,
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic iniciar,
  input  logic confirma,
  input  logic [largura_vidas(MAX_VIDAS)-1:0] vidas_sel,
  input  logic borda_movimento,
  input  logic colisao,
  input  logic fim_mapa,
  input  logic pausa,
  output logic zeraPosicoes,
  output logic desloca,
  output logic checa_colisao_out,
  output logic [largura_vidas(MAX_VIDAS)-1:0] vidas_restantes,
  output logic [largura_nivel(N_NIVEIS)-1:0] nivel,
  output logic timeout_out,
  output logic venceu,
  output logic perdeu,
  output logic [3:0] db_estado
);

  localparam int VW = largura_vidas(MAX_VIDAS);
  localparam int NW = largura_nivel(N_NIVEIS);
  localparam logic [VW-1:0] VIDAS_MAX    = VW'(MAX_VIDAS);
  localparam logic [NW-1:0] ULTIMO_NIVEL = NW'(N_NIVEIS - 1);
`ifdef UNIDADE_CONTROLE_PAUSA_EN
  localparam logic PAUSA_EN = 1'b1;
`else
  localparam logic PAUSA_EN = 1'b0;
`endif

  estado_t       r_estado;
  logic [VW-1:0] r_vidas;
  logic [NW-1:0] r_nivel;
  logic          w_fim;
  logic          w_zera_cont;
  logic          w_conta;
  logic          w_pausa;
  logic [VW-1:0] w_vidas_ini;

  // pausa is masked off entirely when the feature is not built in
  assign w_pausa     = pausa & PAUSA_EN;
  assign w_conta     = (r_estado == ESPERA);
  assign w_zera_cont = r_estado inside {INICIAL, PREPARACAO,
                                        PROXIMO, PERDE_VIDA};

  always_comb begin
    w_vidas_ini = vidas_sel;
    if (vidas_sel == '0) begin
      w_vidas_ini = VW'(1);
    end else if (vidas_sel > VIDAS_MAX) begin
      w_vidas_ini = VIDAS_MAX;
    end
  end

  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_timeout (
    .clock(clock),
    .reset(reset),
    .zera (w_zera_cont),
    .conta(w_conta),
    .fim  (w_fim)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= INICIAL;
      r_vidas  <= '0;
      r_nivel  <= '0;
    end else begin
      case (r_estado)
        INICIAL: if (iniciar) r_estado <= VIDAS;
        VIDAS: begin
          if (confirma) begin
            r_estado <= PREPARACAO;
            r_vidas  <= w_vidas_ini;
            r_nivel  <= '0;
          end
        end
        PREPARACAO:   r_estado <= ESPERA;
        ESPERA: begin
          if (w_fim)                r_estado <= PERDE_VIDA;
          else if (w_pausa)         r_estado <= PAUSA;
          else if (borda_movimento) r_estado <= DESLOCAMENTO;
        end
        DESLOCAMENTO: r_estado <= CHECA;
        CHECA: r_estado <= colisao ? PERDE_VIDA : PROXIMO;
        PROXIMO: begin
          if (!fim_mapa)                   r_estado <= ESPERA;
          else if (r_nivel == ULTIMO_NIVEL) r_estado <= VITORIA;
          else                             r_estado <= NOVO_NIVEL;
        end
        PERDE_VIDA: begin
          if (r_vidas != '0) r_vidas <= r_vidas - VW'(1);
          r_estado <= (r_vidas <= VW'(1)) ? DERROTA : PREPARACAO;
        end
        NOVO_NIVEL: begin
          if (r_nivel != ULTIMO_NIVEL) r_nivel <= r_nivel + NW'(1);
          r_estado <= PREPARACAO;
        end
`ifdef UNIDADE_CONTROLE_PAUSA_EN
        PAUSA: if (confirma && !pausa) r_estado <= ESPERA;
`endif
        DERROTA, VITORIA: if (iniciar) r_estado <= VIDAS;
        default: r_estado <= INICIAL;
      endcase
    end
  end

  assign zeraPosicoes      = (r_estado == INICIAL) ||
                             (r_estado == PREPARACAO);
  assign desloca           = (r_estado == ESPERA);
  assign checa_colisao_out = (r_estado == CHECA);
  assign timeout_out       = (r_estado == ESPERA) && w_fim;
  assign perdeu            = (r_estado == DERROTA);
  assign venceu            = (r_estado == VITORIA);
  assign vidas_restantes   = r_vidas;
  assign nivel             = r_nivel;

  always_comb begin
    db_estado = r_estado;
    if (!estado_valido(r_estado, PAUSA_EN)) db_estado = DB_INVALIDO;
  end

endmodule

// File: tb/tb_unidade_controle_niveis.sv
// Vector/scoreboard bench for unidade_controle_niveis.
// Runs with MAX_VIDAS=3, N_NIVEIS=2, TIMEOUT_CICLOS=8.
module tb_unidade_controle_niveis;

  localparam logic [5:0] I_NADA = 6'b000000;
  localparam logic [5:0] I_INI  = 6'b100000;
  localparam logic [5:0] I_CONF = 6'b010000;
  localparam logic [5:0] I_BOR  = 6'b001000;
  localparam logic [5:0] I_COL  = 6'b000100;
  localparam logic [5:0] I_FIM  = 6'b000010;
  localparam logic [5:0] I_PAU  = 6'b000001;

  typedef struct {
    string       nome;
    logic [5:0]  in;
    logic [1:0]  sel;
    logic [3:0]  est;
    logic [1:0]  vid;
    logic        niv;
    logic        tmo;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       iniciar = 1'b0;
  logic       confirma = 1'b0;
  logic [1:0] vidas_sel = 2'd0;
  logic       borda_movimento = 1'b0;
  logic       colisao = 1'b0;
  logic       fim_mapa = 1'b0;
  logic       pausa = 1'b0;
  logic       zeraPosicoes;
  logic       desloca;
  logic       checa_colisao_out;
  logic [1:0] vidas_restantes;
  logic       nivel;
  logic       timeout_out;
  logic       venceu;
  logic       perdeu;
  logic [3:0] db_estado;

  int n_vec = 0;
  int n_err = 0;
  vec_t tab[$];
  vec_t exp_q[$];

  unidade_controle_niveis #(
    .MAX_VIDAS     (3),
    .N_NIVEIS      (2),
    .TIMEOUT_CICLOS(8)
  ) dut (
    .clock            (clk),
    .reset            (rst_n),
    .iniciar          (iniciar),
    .confirma         (confirma),
    .vidas_sel        (vidas_sel),
    .borda_movimento  (borda_movimento),
    .colisao          (colisao),
    .fim_mapa         (fim_mapa),
    .pausa            (pausa),
    .zeraPosicoes     (zeraPosicoes),
    .desloca          (desloca),
    .checa_colisao_out(checa_colisao_out),
    .vidas_restantes  (vidas_restantes),
    .nivel            (nivel),
    .timeout_out      (timeout_out),
    .venceu           (venceu),
    .perdeu           (perdeu),
    .db_estado        (db_estado)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input string      n,
    input logic [5:0] in,
    input logic [1:0] sel,
    input logic [3:0] est,
    input logic [1:0] vid,
    input logic       niv,
    input logic       tmo
  );
    vec_t v;
    v.nome = n;
    v.in   = in;
    v.sel  = sel;
    v.est  = est;
    v.vid  = vid;
    v.niv  = niv;
    v.tmo  = tmo;
    return v;
  endfunction

  // flags: zera, desloca, checa, timeout, venceu, perdeu
  function automatic logic [5:0] flags_esperadas(input vec_t v);
    return {(v.est == 4'h0) || (v.est == 4'h2), v.est == 4'h3,
            v.est == 4'h5, v.tmo, v.est == 4'hB, v.est == 4'hA};
  endfunction

  task automatic compara(input vec_t v);
    logic [5:0] f_dut;
    logic [5:0] f_exp;
    f_dut = {zeraPosicoes, desloca, checa_colisao_out,
             timeout_out, venceu, perdeu};
    f_exp = flags_esperadas(v);
    n_vec++;
    if (db_estado !== v.est || vidas_restantes !== v.vid ||
        nivel !== v.niv || f_dut !== f_exp) begin
      n_err++;
      $display("FAIL %s: got est=%h vid=%0d niv=%0d flags=%b, want est=%h vid=%0d niv=%0d flags=%b",
               v.nome, db_estado, vidas_restantes, nivel, f_dut,
               v.est, v.vid, v.niv, f_exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    {iniciar, confirma, borda_movimento, colisao, fim_mapa, pausa} = v.in;
    vidas_sel = v.sel;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    compara(exp_q.pop_front());
  endtask

  task automatic chk_now(input vec_t v);
    exp_q.push_back(v);
    compara(exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // game A: one life, level advance, victory
    tab.push_back(mk("idle_inicial", I_NADA, 2'd0, 4'h0, 2'd0, 1'b0, 1'b0));
    tab.push_back(mk("iniciar", I_INI, 2'd0, 4'h1, 2'd0, 1'b0, 1'b0));
    tab.push_back(mk("vidas_ign_ini", I_INI, 2'd0, 4'h1, 2'd0, 1'b0, 1'b0));
    tab.push_back(mk("sel0_clamp", I_CONF, 2'd0, 4'h2, 2'd1, 1'b0, 1'b0));
    tab.push_back(mk("prep_espera", I_NADA, 2'd0, 4'h3, 2'd1, 1'b0, 1'b0));
    tab.push_back(mk("espera_ign_ini", I_INI | I_CONF, 2'd0, 4'h3, 2'd1, 1'b0, 1'b0));
    tab.push_back(mk("mov_a", I_BOR, 2'd0, 4'h4, 2'd1, 1'b0, 1'b0));
    tab.push_back(mk("checa_a", I_NADA, 2'd0, 4'h5, 2'd1, 1'b0, 1'b0));
    tab.push_back(mk("sem_colisao_a", I_NADA, 2'd0, 4'h6, 2'd1, 1'b0, 1'b0));
    tab.push_back(mk("prox_fim0", I_NADA, 2'd0, 4'h3, 2'd1, 1'b0, 1'b0));
    tab.push_back(mk("mov_b", I_BOR, 2'd0, 4'h4, 2'd1, 1'b0, 1'b0));
    tab.push_back(mk("checa_b", I_NADA, 2'd0, 4'h5, 2'd1, 1'b0, 1'b0));
    tab.push_back(mk("sem_colisao_b", I_FIM, 2'd0, 4'h6, 2'd1, 1'b0, 1'b0));
    tab.push_back(mk("novo_nivel", I_FIM, 2'd0, 4'h8, 2'd1, 1'b0, 1'b0));
    tab.push_back(mk("nivel1_prep", I_NADA, 2'd0, 4'h2, 2'd1, 1'b1, 1'b0));
    tab.push_back(mk("nivel1_espera", I_NADA, 2'd0, 4'h3, 2'd1, 1'b1, 1'b0));
    tab.push_back(mk("mov_c", I_BOR, 2'd0, 4'h4, 2'd1, 1'b1, 1'b0));
    tab.push_back(mk("checa_c", I_NADA, 2'd0, 4'h5, 2'd1, 1'b1, 1'b0));
    tab.push_back(mk("sem_colisao_c", I_FIM, 2'd0, 4'h6, 2'd1, 1'b1, 1'b0));
    tab.push_back(mk("vitoria", I_FIM, 2'd0, 4'hB, 2'd1, 1'b1, 1'b0));
    tab.push_back(mk("vitoria_hold", I_NADA, 2'd0, 4'hB, 2'd1, 1'b1, 1'b0));
    tab.push_back(mk("vitoria_conf", I_CONF, 2'd0, 4'hB, 2'd1, 1'b1, 1'b0));
    tab.push_back(mk("reinicia", I_INI, 2'd0, 4'h1, 2'd1, 1'b1, 1'b0));
    // game B: three lives, collision, timeouts, defeat
    tab.push_back(mk("sel7_clamp", I_CONF, 2'(7), 4'h2, 2'd3, 1'b0, 1'b0));
    tab.push_back(mk("b_espera", I_NADA, 2'd0, 4'h3, 2'd3, 1'b0, 1'b0));
    tab.push_back(mk("b_mov", I_BOR, 2'd0, 4'h4, 2'd3, 1'b0, 1'b0));
    tab.push_back(mk("b_checa", I_NADA, 2'd0, 4'h5, 2'd3, 1'b0, 1'b0));
    tab.push_back(mk("colisao", I_COL, 2'd0, 4'h7, 2'd3, 1'b0, 1'b0));
    tab.push_back(mk("colisao_prep", I_NADA, 2'd0, 4'h2, 2'd2, 1'b0, 1'b0));
    tab.push_back(mk("b_espera2", I_NADA, 2'd0, 4'h3, 2'd2, 1'b0, 1'b0));
    for (int k = 1; k <= 7; k++)
      tab.push_back(mk("timeout_a", I_NADA, 2'd0, 4'h3, 2'd2, 1'b0, k == 7));
    tab.push_back(mk("prio_timeout", I_PAU | I_BOR, 2'd0, 4'h7, 2'd2, 1'b0, 1'b0));
    tab.push_back(mk("perde_prep", I_NADA, 2'd0, 4'h2, 2'd1, 1'b0, 1'b0));
    tab.push_back(mk("b_espera3", I_NADA, 2'd0, 4'h3, 2'd1, 1'b0, 1'b0));
    for (int k = 1; k <= 7; k++)
      tab.push_back(mk("timeout_b", I_NADA, 2'd0, 4'h3, 2'd1, 1'b0, k == 7));
    tab.push_back(mk("perde_ultima", I_NADA, 2'd0, 4'h7, 2'd1, 1'b0, 1'b0));
    tab.push_back(mk("derrota", I_NADA, 2'd0, 4'hA, 2'd0, 1'b0, 1'b0));
    tab.push_back(mk("derrota_hold", I_NADA, 2'd0, 4'hA, 2'd0, 1'b0, 1'b0));
    tab.push_back(mk("derrota_ini", I_INI, 2'd0, 4'h1, 2'd0, 1'b0, 1'b0));
    tab.push_back(mk("sel2", I_CONF, 2'd2, 4'h2, 2'd2, 1'b0, 1'b0));
    tab.push_back(mk("c_espera", I_NADA, 2'd0, 4'h3, 2'd2, 1'b0, 1'b0));
    for (int k = 1; k <= 3; k++)
      tab.push_back(mk("conta_ate3", I_NADA, 2'd0, 4'h3, 2'd2, 1'b0, 1'b0));

    // power-on reset, then reset held across a clock edge
    #1 rst_n = 1'b0;
    #1 chk_now(mk("reset_inicial", I_NADA, 2'd0, 4'h0, 2'd0, 1'b0, 1'b0));
    run_vec(mk("reset_ignora_ini", I_INI, 2'd0, 4'h0, 2'd0, 1'b0, 1'b0));
    @(negedge clk);
    iniciar = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < tab.size(); i++) run_vec(tab[i]);

    // pause taken at count 3
`ifdef UNIDADE_CONTROLE_PAUSA_EN
    run_vec(mk("pausa_entra", I_PAU, 2'd0, 4'h9, 2'd2, 1'b0, 1'b0));
    for (int k = 1; k < 20; k++)
      run_vec(mk("pausa_hold", (k == 10) ? (I_PAU | I_CONF) : I_PAU,
                 2'd0, 4'h9, 2'd2, 1'b0, 1'b0));
    run_vec(mk("pausa_sai", I_CONF, 2'd0, 4'h3, 2'd2, 1'b0, 1'b0));
    run_vec(mk("pos_pausa_c5", I_NADA, 2'd0, 4'h3, 2'd2, 1'b0, 1'b0));
    run_vec(mk("pos_pausa_c6", I_NADA, 2'd0, 4'h3, 2'd2, 1'b0, 1'b0));
    run_vec(mk("pos_pausa_tmo", I_NADA, 2'd0, 4'h3, 2'd2, 1'b0, 1'b1));
    run_vec(mk("pos_pausa_perde", I_NADA, 2'd0, 4'h7, 2'd2, 1'b0, 1'b0));
`else
    for (int k = 4; k <= 7; k++)
      run_vec(mk("pausa_ignorada", I_PAU, 2'd0, 4'h3, 2'd2, 1'b0, k == 7));
    run_vec(mk("pausa_ign_perde", I_PAU, 2'd0, 4'h7, 2'd2, 1'b0, 1'b0));
`endif
    run_vec(mk("d_prep", I_NADA, 2'd0, 4'h2, 2'd1, 1'b0, 1'b0));
    run_vec(mk("d_espera", I_NADA, 2'd0, 4'h3, 2'd1, 1'b0, 1'b0));

    // asynchronous reset mid-ESPERA, checked before any clock edge
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_now(mk("reset_async", I_NADA, 2'd0, 4'h0, 2'd0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk("pos_reset_ini", I_INI, 2'd0, 4'h1, 2'd0, 1'b0, 1'b0));
    run_vec(mk("sel3_max", I_CONF, 2'd3, 4'h2, 2'd3, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unidade_controle_niveis.md
UNIDADE_CONTROLE_NIVEIS -- requirements
Module: unidade_controle_niveis

Interface
REQ-001 SHALL have parameter MAX_VIDAS, default 3, max lives selectable (1..15).
REQ-002 SHALL have parameter N_NIVEIS, default 4, levels per game (2..16).
REQ-003 SHALL have parameter TIMEOUT_CICLOS, default 5000, clock cycles allowed in ESPERA per move.
REQ-004 SHALL have ports: clock  in  1  system clock; reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have inputs: iniciar 1 start/restart; confirma 1 confirm selection/leave pause; vidas_sel VW=$clog2(MAX_VIDAS+1) requested lives; borda_movimento 1 move pulse; colisao 1 collision flag; fim_mapa 1 end of current map; pausa 1 pause request.
REQ-006 SHALL have outputs: zeraPosicoes 1; desloca 1; checa_colisao_out 1; vidas_restantes VW; nivel NW=$clog2(N_NIVEIS); timeout_out 1; venceu 1; perdeu 1; db_estado 4.

Function
REQ-007 SHALL be a Moore FSM, states/db_estado codes: INICIAL 0, VIDAS 1, PREPARACAO 2, ESPERA 3, DESLOCAMENTO 4, CHECA 5, PROXIMO 6, PERDE_VIDA 7, NOVO_NIVEL 8, PAUSA 9, DERROTA A, VITORIA B; undefined codes -> INICIAL, db_estado F.
REQ-008 SHALL transition: INICIAL -iniciar-> VIDAS; VIDAS -confirma-> PREPARACAO; PREPARACAO -> ESPERA unconditionally; DESLOCAMENTO -> CHECA; NOVO_NIVEL -> PREPARACAO.
REQ-009 ESPERA SHALL use priority timeout > pausa > borda_movimento: timeout -> PERDE_VIDA, pausa -> PAUSA, borda_movimento -> DESLOCAMENTO, else stay.
REQ-010 CHECA SHALL go to PERDE_VIDA if colisao=1, else PROXIMO.
REQ-011 PROXIMO SHALL go to ESPERA if fim_mapa=0; VITORIA if fim_mapa=1 and nivel=N_NIVEIS-1; else NOVO_NIVEL.
REQ-012 PERDE_VIDA SHALL decrement vidas_restantes by 1 and go to DERROTA if pre-decrement value is 1, else PREPARACAO.
REQ-013 DERROTA and VITORIA SHALL hold until iniciar=1, then go to VIDAS.
REQ-014 On VIDAS with confirma=1, vidas_restantes SHALL load vidas_sel clamped to 1..MAX_VIDAS (0 -> 1, >MAX -> MAX) and nivel SHALL clear to 0.
REQ-015 NOVO_NIVEL SHALL increment nivel by 1 (never wraps; PROXIMO guards the last level).
REQ-016 Timeout counter SHALL increment once per clock in ESPERA, hold in PAUSA, clear in INICIAL/PREPARACAO/PROXIMO/PERDE_VIDA; timeout asserted when count = TIMEOUT_CICLOS-1.
REQ-017 timeout_out SHALL be 1 exactly in the ESPERA cycle where timeout is asserted.
REQ-018 Outputs SHALL decode: zeraPosicoes in INICIAL/PREPARACAO; desloca in ESPERA; checa_colisao_out in CHECA; perdeu in DERROTA; venceu in VITORIA.
REQ-019 PAUSA SHALL return to ESPERA when confirma=1 and pausa=0; otherwise stay.
REQ-020 iniciar SHALL be ignored in all states except INICIAL, DERROTA, VITORIA.

Reset
REQ-021 reset=0 SHALL immediately force INICIAL, vidas_restantes=0, nivel=0, timeout counter=0, regardless of clock, including mid-game.
REQ-022 During/after reset outputs SHALL be: zeraPosicoes=1, db_estado=0, all other outputs 0.

Configuration
REQ-023 With macro UNIDADE_CONTROLE_PAUSA_EN defined, pausa/PAUSA behave per REQ-009/016/019.
REQ-024 Without UNIDADE_CONTROLE_PAUSA_EN, pausa port SHALL remain but be ignored, PAUSA unreachable, db_estado 9 never produced.

Structure
REQ-025 State encodings, db_estado codes and width helpers SHALL live in shared package drone_pkg.
REQ-026 Timeout counter SHALL be sub-module contador_timeout (params TIMEOUT_CICLOS; inputs zera, conta; output fim).

Verification (bench params MAX_VIDAS=3, N_NIVEIS=2, TIMEOUT_CICLOS=8)
REQ-027 reset=0 mid-ESPERA -> db_estado=0, vidas_restantes=0, zeraPosicoes=1 without clock edge.
REQ-028 iniciar, confirma with vidas_sel=0 -> vidas_restantes=1; vidas_sel=7 -> vidas_restantes=3.
REQ-029 Lives 2, idle 8 cycles in ESPERA -> timeout_out pulse on 8th cycle, PERDE_VIDA, vidas_restantes=1, PREPARACAO; repeat -> DERROTA, perdeu=1.
REQ-030 Move with colisao=0, fim_mapa=1 at nivel 0 -> NOVO_NIVEL, nivel=1, PREPARACAO; again at nivel 1 -> VITORIA, venceu=1.
REQ-031 Same cycle timeout=1, pausa=1, borda_movimento=1 in ESPERA -> PERDE_VIDA.
REQ-032 PAUSA_EN: pausa at count 3, hold 20 cycles, confirma -> ESPERA, timeout after 4 more cycles; without macro pausa ignored.
